mem_arbiter: RTL
================

# mem_arbiter

Two-to-one arbiter that lets the core's instruction port and data port share one unified memory port. It sits between the core and the memory and accepts one request at a time from either port. It issues that request downstream, holds it until the memory accepts it, and routes the single response back to the port that issued it. Data requests have priority, bounded by a streak counter so that instruction fetch is never starved.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `MAX_DSTREAK`, 4, maximum consecutive data grants while a fetch waits (≥1)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `imem_req_valid` in 1 / `imem_req_ready` out 1 / `imem_req_addr` in AW: fetch request; read only
- `imem_resp_valid` out 1 / `imem_resp_data` out DW: fetch response
- `dmem_req_valid` in 1 / `dmem_req_ready` out 1 / `dmem_req_addr` in AW: data request
- `dmem_req_wen` in 1 / `dmem_req_wdata` in DW / `dmem_req_wstrb` in DW/8: write enable, write data, byte strobes
- `dmem_resp_valid` out 1 / `dmem_resp_data` out DW: data response; on writes this is an acknowledge and the data is don't-care
- `mem_req_valid` out 1 / `mem_req_ready` in 1: downstream request handshake
- `mem_req_addr` out AW / `mem_req_wen` out 1 / `mem_req_wdata` out DW / `mem_req_wstrb` out DW/8: downstream request payload
- `mem_resp_valid` in 1 / `mem_resp_data` in DW: downstream response; exactly one per accepted request, for reads and writes
- `owner` out 1: current owner; 0 = imem, 1 = dmem
- `err_stray_resp` out 1: sticky flag, set when a response arrives outside WAIT

## Operation
- States are IDLE, ISSUE and WAIT. Exactly one transaction is outstanding at a time.
- **IDLE:**
  - If either `*_req_valid` is high, pick a winner.
  - Assert the winner's `*_req_ready` combinationally in that cycle; the loser's ready stays 0.
  - Latch addr, wen, wdata and wstrb into output registers. Latch `owner`.
  - Next state is ISSUE.
  - For imem the latched values are wen=0, wdata=0, wstrb=0.
- **Arbitration:**
  - If only one port requests, it wins.
  - If both request, dmem wins unless `dstreak == MAX_DSTREAK`; then imem wins.
- **Streak counter** (`dstreak`, width clog2(MAX_DSTREAK+1)):
  - +1 when dmem wins while `imem_req_valid` is high.
  - Cleared when imem wins.
  - Cleared when dmem wins while `imem_req_valid` is low.
  - Never exceeds MAX_DSTREAK.
- **ISSUE:**
  - `mem_req_valid` is high, driven from the registers.
  - Payload is stable while valid and ready are not both high.
  - On `mem_req_valid && mem_req_ready`, go to WAIT.
- **WAIT:**
  - `mem_req_valid` is 0.
  - On `mem_resp_valid`, drive the owner's `*_resp_valid` high combinationally for that cycle. `*_resp_data` equals `mem_resp_data`. Next state is IDLE.
  - The non-owner's resp_valid is always 0.
- `*_resp_data` outputs mirror `mem_resp_data` at all times; only the valid signals are gated.
- **Stray response:** `mem_resp_valid` in IDLE or ISSUE is ignored and sets `err_stray_resp`. The flag is cleared only by reset.
- Requesters hold valid and payload until ready. The arbiter does not track withdrawn requests.

## Timing
- Reset values: state=IDLE, `dstreak`=0, `owner`=0, `mem_req_*`=0, all `*_ready`=0, all `*_resp_valid`=0, `err_stray_resp`=0.
- Reset mid-transaction: the transaction is abandoned. A late response arriving after reset sets `err_stray_resp`.
- Accept latency: a request valid in an IDLE cycle N gets ready in cycle N.
- `mem_req_valid` rises at cycle N+1.
- If `mem_req_ready` is high at N+1, the earliest response is N+2; that response is forwarded at N+2.
- IDLE resumes at N+3. The maximum rate is one transaction per 3 cycles.
- Response to the requester has zero added latency, because resp_valid is combinational from `mem_resp_valid` in WAIT.
- There is no combinational path from `mem_req_ready` to any `*_req_ready`.

## Test plan
- **Single fetch:** imem_req addr=0x100. Expect imem_req_ready at cycle 0 and mem_req_addr=0x100 with wen=0 at cycle 1. With mem_req_ready=1 and resp 0xDEADBEEF at cycle 3, expect imem_resp_valid=1 with data 0xDEADBEEF at cycle 3 and dmem_resp_valid=0.
- **Data write:** dmem addr=0x20, wdata=0x12345678, wstrb=0xF. Expect a downstream write with identical payload. Hold mem_req_ready=0 for 3 cycles and confirm the payload is stable. Ack forwarded only on dmem_resp_valid.
- **Contention and anti-starvation** (MAX_DSTREAK=4): hold both valids continuously. Grant order must be D,D,D,D,I,D,D,D,D,I. dstreak peaks at 4.
- **Streak clear:** dmem alone for 6 transactions, then both request. Expect dmem wins, since dstreak was 0.
- **Stray response:** pulse mem_resp_valid in IDLE. Expect err_stray_resp=1 and sticky, with no resp_valid on either port.
- **Reset mid-WAIT:** assert reset low asynchronously during WAIT. Expect all outputs at reset values immediately. A later mem_resp_valid is not forwarded and sets err_stray_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-to-one arbiter that shares one unified memory port between the core's
// instruction (imem) and data (dmem) ports. One transaction is outstanding at
// a time: a request is granted in IDLE, presented downstream in ISSUE until
// the memory accepts it, and the single response is routed back to the
// granted port in WAIT.
//
// Data requests win contention, but a streak counter limits how many data
// grants in a row may pass a waiting fetch, so fetch is never starved.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   imem_req_*                  fetch request (valid/ready, addr); read only
//   imem_resp_*                 fetch response (valid, data)
//   dmem_req_*                  data request (valid/ready, addr, wen, wdata,
//                               wstrb)
//   dmem_resp_*                 data response; write ack carries don't-care
//   mem_req_*                   downstream request (valid/ready + payload)
//   mem_resp_*                  downstream response, one per accepted request
//   owner                       port owning the current transaction
//                               (0 = imem, 1 = dmem)
//   err_stray_resp              sticky: response seen outside WAIT
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; grant a requester in the cycle it is valid
// ISSUE | mem_req_valid high with latched payload, waiting for ready
// WAIT  | request accepted, waiting for the single response
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            imem_req_valid,
    output logic            imem_req_ready,
    input  logic [AW-1:0]   imem_req_addr,
    output logic            imem_resp_valid,
    output logic [DW-1:0]   imem_resp_data,

    input  logic            dmem_req_valid,
    output logic            dmem_req_ready,
    input  logic [AW-1:0]   dmem_req_addr,
    input  logic            dmem_req_wen,
    input  logic [DW-1:0]   dmem_req_wdata,
    input  logic [DW/8-1:0] dmem_req_wstrb,
    output logic            dmem_resp_valid,
    output logic [DW-1:0]   dmem_resp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wstrb,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_data,

    output logic            owner,
    output logic            err_stray_resp
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t         state;
    logic [SW-1:0]  dstreak;
    logic           streak_full;
    logic           grant_d;
    logic           grant_i;
    logic           resp_fire;

    assign streak_full = (dstreak == SW'(MAX_DSTREAK));

    // Grant decision. Qualified with reset so the readies sit at their reset
    // value while reset is held, even if a requester keeps valid high.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (reset && (state == S_IDLE)) begin
            if (dmem_req_valid && !(imem_req_valid && streak_full)) begin
                grant_d = 1'b1;
            end else if (imem_req_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    assign imem_req_ready = grant_i;
    assign dmem_req_ready = grant_d;

    // Responses pass straight through; only the valids are steered.
    assign resp_fire       = (state == S_WAIT) && mem_resp_valid;
    assign imem_resp_valid = resp_fire && !owner;
    assign dmem_resp_valid = resp_fire && owner;
    assign imem_resp_data  = mem_resp_data;
    assign dmem_resp_data  = mem_resp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            dstreak        <= '0;
            owner          <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wen    <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wstrb  <= '0;
            err_stray_resp <= 1'b0;
        end else begin
            if (mem_resp_valid && (state != S_WAIT)) begin
                err_stray_resp <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        owner         <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= dmem_req_addr;
                        mem_req_wen   <= dmem_req_wen;
                        mem_req_wdata <= dmem_req_wdata;
                        mem_req_wstrb <= dmem_req_wstrb;
                        state         <= S_ISSUE;
                        // A data grant only counts against the fetch if a
                        // fetch was actually waiting. The grant condition
                        // keeps the increment from passing MAX_DSTREAK.
                        if (imem_req_valid) begin
                            dstreak <= dstreak + SW'(1);
                        end else begin
                            dstreak <= '0;
                        end
                    end else if (grant_i) begin
                        owner         <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= imem_req_addr;
                        mem_req_wen   <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_wstrb <= BW'(0);
                        state         <= S_ISSUE;
                        dstreak       <= '0;
                    end
                end

                S_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
